// File: rtl/sc_regbank_pkg.sv
// Shared register-bank constants: special register indices and PSR flag positions.
// Also holds the helper that packs the four ALU flags into PSR order.
package sc_regbank_pkg;

  localparam int REG_ZERO  = 0;
  localparam int REG_PC    = 32;
  localparam int REG_TEMP0 = 33;
  localparam int REG_IR    = 37;
  localparam int NUM_REGS  = 38;

  localparam int PSR_N = 3;
  localparam int PSR_Z = 2;
  localparam int PSR_V = 1;
  localparam int PSR_C = 0;

  // ALU flags arrive active low; the PSR stores them active high.
  function automatic logic [3:0] psr_pack(input logic neg_n, input logic zero_n,
                                          input logic ovf_n, input logic carry_n);
    logic [3:0] f;
    f        = '0;
    f[PSR_N] = ~neg_n;
    f[PSR_Z] = ~zero_n;
    f[PSR_V] = ~ovf_n;
    f[PSR_C] = ~carry_n;
    return f;
  endfunction

endpackage

// File: rtl/sc_regbank_psr.sv
// Processor status register: 4-bit {n,z,v,c} flag register with load enable.
// Synchronous active-high reset clears all flags.
module sc_psr (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_load,
  input  logic [3:0] i_flags,
  output logic [3:0] o_psr
);

  logic [3:0] r_psr;

  always_ff @(posedge i_clk) begin
    if (i_rst)
      r_psr <= '0;
    else if (i_load)
      r_psr <= i_flags;
  end

  assign o_psr = r_psr;

endmodule

// File: rtl/sc_regbank.sv
// ARC datapath register bank: r1-r31, %pc, %temp0-3, %ir with two combinational
// read ports, one write-back port, a dedicated %ir load port and the PSR.
module sc_regbank #(
  parameter int DATAWIDTH_BUS    = 32,
  parameter int DATAWIDTH_REGSEL = 6,
  parameter int NUM_REGS         = sc_regbank_pkg::NUM_REGS
) (
  input  logic                        SC_REGBANK_CLOCK_50,
  input  logic                        SC_REGBANK_RESET_InHigh,
  input  logic [DATAWIDTH_REGSEL-1:0] SC_REGBANK_aAddr_InBUS,
  input  logic [DATAWIDTH_REGSEL-1:0] SC_REGBANK_bAddr_InBUS,
  input  logic [DATAWIDTH_REGSEL-1:0] SC_REGBANK_cAddr_InBUS,
  input  logic                        SC_REGBANK_cWrite_InLow,
  input  logic [DATAWIDTH_BUS-1:0]    SC_REGBANK_cData_InBUS,
  input  logic                        SC_REGBANK_irLoad_InLow,
  input  logic [DATAWIDTH_BUS-1:0]    SC_REGBANK_irData_InBUS,
  input  logic                        SC_REGBANK_overflow_InLow,
  input  logic                        SC_REGBANK_carry_InLow,
  input  logic                        SC_REGBANK_negative_InLow,
  input  logic                        SC_REGBANK_zero_InLow,
  input  logic                        SC_REGBANK_setFlags_InLow,
  output logic [DATAWIDTH_BUS-1:0]    SC_REGBANK_aData_OutBUS,
  output logic [DATAWIDTH_BUS-1:0]    SC_REGBANK_bData_OutBUS,
  output logic [DATAWIDTH_BUS-1:0]    SC_REGBANK_pc_OutBUS,
  output logic [DATAWIDTH_BUS-1:0]    SC_REGBANK_ir_OutBUS,
  output logic [3:0]                  SC_REGBANK_psr_OutBUS
);

  import sc_regbank_pkg::*;

  // r0 is hard-wired to zero, so storage starts at index 1.
  logic [DATAWIDTH_BUS-1:0] r_regs [1:NUM_REGS-1];
  logic [NUM_REGS-1:1]      w_wrSel;
  logic [DATAWIDTH_BUS-1:0] w_aData;
  logic [DATAWIDTH_BUS-1:0] w_bData;
  logic [3:0]               w_flags;
  logic                     w_psrLoad;

  // Addresses 0 and >= NUM_REGS match no select line, so those writes vanish.
  always_comb begin
    w_wrSel = '0;
    for (int i = 1; i < NUM_REGS; i++)
      w_wrSel[i] = !SC_REGBANK_cWrite_InLow &&
                   (SC_REGBANK_cAddr_InBUS == DATAWIDTH_REGSEL'(i));
  end

  always_ff @(posedge SC_REGBANK_CLOCK_50) begin
    if (SC_REGBANK_RESET_InHigh) begin
      for (int i = 1; i < NUM_REGS; i++)
        r_regs[i] <= '0;
    end else begin
      for (int i = 1; i < NUM_REGS; i++)
        if (w_wrSel[i])
          r_regs[i] <= SC_REGBANK_cData_InBUS;
      // Placed last so the instruction load overrides a same-cycle C write to %ir.
      if (!SC_REGBANK_irLoad_InLow)
        r_regs[REG_IR] <= SC_REGBANK_irData_InBUS;
    end
  end

  always_comb begin
    w_aData = '0;
    w_bData = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (SC_REGBANK_aAddr_InBUS == DATAWIDTH_REGSEL'(i))
        w_aData = r_regs[i];
      if (SC_REGBANK_bAddr_InBUS == DATAWIDTH_REGSEL'(i))
        w_bData = r_regs[i];
    end
  end

  assign w_flags   = psr_pack(SC_REGBANK_negative_InLow, SC_REGBANK_zero_InLow,
                              SC_REGBANK_overflow_InLow, SC_REGBANK_carry_InLow);
  assign w_psrLoad = ~SC_REGBANK_setFlags_InLow;

  sc_psr u_psr (
    .i_clk   (SC_REGBANK_CLOCK_50),
    .i_rst   (SC_REGBANK_RESET_InHigh),
    .i_load  (w_psrLoad),
    .i_flags (w_flags),
    .o_psr   (SC_REGBANK_psr_OutBUS)
  );

  assign SC_REGBANK_aData_OutBUS = w_aData;
  assign SC_REGBANK_bData_OutBUS = w_bData;
  assign SC_REGBANK_pc_OutBUS    = r_regs[REG_PC];
  assign SC_REGBANK_ir_OutBUS    = r_regs[REG_IR];

endmodule

// File: tb/tb_sc_regbank.sv
// Bench for sc_regbank: directed vector table, hand-written reset sequences and
// randomized traffic compared against an array-based reference model.
module tb_sc_regbank;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  a_addr, b_addr, c_addr;
  logic        c_we_n, ir_n, ovf_n, car_n, neg_n, zer_n, sf_n;
  logic [31:0] c_data, ir_data;
  logic [31:0] a_data, b_data, pc_out, ir_out;
  logic [3:0]  psr_out;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_regs [0:37];
  logic [3:0]  m_psr;

  sc_regbank dut (
    .SC_REGBANK_CLOCK_50       (clk),
    .SC_REGBANK_RESET_InHigh   (rst),
    .SC_REGBANK_aAddr_InBUS    (a_addr),
    .SC_REGBANK_bAddr_InBUS    (b_addr),
    .SC_REGBANK_cAddr_InBUS    (c_addr),
    .SC_REGBANK_cWrite_InLow   (c_we_n),
    .SC_REGBANK_cData_InBUS    (c_data),
    .SC_REGBANK_irLoad_InLow   (ir_n),
    .SC_REGBANK_irData_InBUS   (ir_data),
    .SC_REGBANK_overflow_InLow (ovf_n),
    .SC_REGBANK_carry_InLow    (car_n),
    .SC_REGBANK_negative_InLow (neg_n),
    .SC_REGBANK_zero_InLow     (zer_n),
    .SC_REGBANK_setFlags_InLow (sf_n),
    .SC_REGBANK_aData_OutBUS   (a_data),
    .SC_REGBANK_bData_OutBUS   (b_data),
    .SC_REGBANK_pc_OutBUS      (pc_out),
    .SC_REGBANK_ir_OutBUS      (ir_out),
    .SC_REGBANK_psr_OutBUS     (psr_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  c_addr;
    logic        c_we_n;
    logic [31:0] c_data;
    logic        ir_n;
    logic [31:0] ir_data;
    logic [3:0]  flags_n;   // {neg, zero, ovf, carry}, active low
    logic        sf_n;
    logic [5:0]  rd_addr;
    logic [31:0] exp_pre;
    logic [31:0] exp_post;
    logic [31:0] exp_ir;
    logic [3:0]  exp_psr;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [5:0] a);
    if (a == 0 || a >= 38) return 32'h0;
    return m_regs[a];
  endfunction

  // Reference behaviour at a clock edge, derived from the register-bank rules.
  task automatic m_commit();
    if (rst) begin
      for (int i = 0; i < 38; i++) m_regs[i] = 32'h0;
      m_psr = 4'h0;
    end else begin
      if (!c_we_n && c_addr != 0 && c_addr < 38) m_regs[c_addr] = c_data;
      if (!ir_n) m_regs[37] = ir_data;
      if (!sf_n) m_psr = {~neg_n, ~zer_n, ~ovf_n, ~car_n};
    end
  endtask

  task automatic step();
    m_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    c_we_n = 1'b1; ir_n = 1'b1; sf_n = 1'b1;
    c_addr = '0; c_data = '0; ir_data = '0;
    {neg_n, zer_n, ovf_n, car_n} = 4'hF;
  endtask

  task automatic scan_model(input string name);
    for (int i = 0; i < 64; i++) begin
      a_addr = 6'(i);
      b_addr = 6'(63 - i);
      #1;
      check({name, "_a"}, a_data, m_read(6'(i)));
      check({name, "_b"}, b_data, m_read(6'(63 - i)));
    end
  endtask

  initial begin
    for (int i = 0; i < 38; i++) m_regs[i] = 32'h0;
    m_psr = 4'h0;
    idle();
    a_addr = '0; b_addr = '0;

    // Reset with writes to r7, %pc and PSR pending: reset must win.
    rst = 1'b1;
    c_we_n = 1'b0; c_addr = 6'd7; c_data = 32'hCAFE0007;
    ir_n = 1'b0; ir_data = 32'h99999999;
    sf_n = 1'b0; {neg_n, zer_n, ovf_n, car_n} = 4'h0;
    step();
    c_addr = 6'd32; c_data = 32'h00000400;
    step();
    check("rst_psr", {28'h0, psr_out}, 32'h0);
    check("rst_pc", pc_out, 32'h0);
    check("rst_ir", ir_out, 32'h0);
    for (int i = 0; i < 38; i++) begin
      a_addr = 6'(i); b_addr = 6'(37 - i);
      #1;
      check("rst_rd_a", a_data, 32'h0);
      check("rst_rd_b", b_data, 32'h0);
    end
    rst = 1'b0;
    idle();

    vecs[0] = '{6'd5,  1'b0, 32'hDEADBEEF, 1'b1, 32'h0,        4'hF, 1'b1, 6'd5,  32'h0,        32'hDEADBEEF, 32'h0,        4'b0000};
    vecs[1] = '{6'd0,  1'b0, 32'hFFFFFFFF, 1'b1, 32'h0,        4'hF, 1'b1, 6'd0,  32'h0,        32'h0,        32'h0,        4'b0000};
    vecs[2] = '{6'd40, 1'b0, 32'hFFFFFFFF, 1'b1, 32'h0,        4'hF, 1'b1, 6'd5,  32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        4'b0000};
    vecs[3] = '{6'd37, 1'b0, 32'h11111111, 1'b0, 32'h22222222, 4'hF, 1'b1, 6'd37, 32'h0,        32'h22222222, 32'h22222222, 4'b0000};
    vecs[4] = '{6'd32, 1'b0, 32'h12345678, 1'b1, 32'h0,        4'b0110, 1'b0, 6'd32, 32'h0,     32'h12345678, 32'h22222222, 4'b1001};
    vecs[5] = '{6'd37, 1'b0, 32'h11111111, 1'b1, 32'h0,        4'b0000, 1'b1, 6'd37, 32'h22222222, 32'h11111111, 32'h11111111, 4'b1001};
    vecs[6] = '{6'd5,  1'b1, 32'h55555555, 1'b1, 32'h0,        4'hF, 1'b0, 6'd5,  32'hDEADBEEF, 32'hDEADBEEF, 32'h11111111, 4'b0000};
    vecs[7] = '{6'd3,  1'b1, 32'h0,        1'b0, 32'hAABBCCDD, 4'b1010, 1'b0, 6'd37, 32'h11111111, 32'hAABBCCDD, 32'hAABBCCDD, 4'b0101};

    for (int k = 0; k < 8; k++) begin
      c_addr = vecs[k].c_addr; c_we_n = vecs[k].c_we_n; c_data = vecs[k].c_data;
      ir_n = vecs[k].ir_n; ir_data = vecs[k].ir_data;
      {neg_n, zer_n, ovf_n, car_n} = vecs[k].flags_n;
      sf_n = vecs[k].sf_n;
      a_addr = vecs[k].rd_addr; b_addr = vecs[k].rd_addr;
      #1;
      check("vec_rd_pre", a_data, vecs[k].exp_pre);
      step();
      check("vec_rd_post_a", a_data, vecs[k].exp_post);
      check("vec_rd_post_b", b_data, vecs[k].exp_post);
      check("vec_ir", ir_out, vecs[k].exp_ir);
      check("vec_psr", {28'h0, psr_out}, {28'h0, vecs[k].exp_psr});
      check("vec_pc", pc_out, m_regs[32]);
    end
    idle();
    scan_model("after_vec");

    // Randomized traffic with occasional reset.
    for (int n = 0; n < 300; n++) begin
      rst     = ($urandom_range(0, 24) == 0);
      c_addr  = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(30, 40)) : 6'($urandom_range(0, 63));
      c_we_n  = $urandom_range(0, 2) == 0;
      c_data  = $urandom;
      ir_n    = $urandom_range(0, 2) != 0;
      ir_data = $urandom;
      {neg_n, zer_n, ovf_n, car_n} = 4'($urandom);
      sf_n    = $urandom_range(0, 1) == 1;
      a_addr  = ($urandom_range(0, 1) == 1) ? c_addr : 6'($urandom_range(0, 63));
      b_addr  = 6'($urandom_range(0, 63));
      #1;
      check("rnd_a", a_data, m_read(a_addr));
      check("rnd_b", b_data, m_read(b_addr));
      step();
      check("rnd_pc", pc_out, m_regs[32]);
      check("rnd_ir", ir_out, m_regs[37]);
      check("rnd_psr", {28'h0, psr_out}, {28'h0, m_psr});
    end
    rst = 1'b0;
    idle();
    scan_model("after_rnd");

    // Populate, then reset mid-operation with writes pending, then resume.
    c_we_n = 1'b0; c_addr = 6'd7; c_data = 32'h07070707;
    sf_n = 1'b0; {neg_n, zer_n, ovf_n, car_n} = 4'h0;
    step();
    c_addr = 6'd32; c_data = 32'h00001000;
    step();
    check("pre_rst_psr", {28'h0, psr_out}, 32'hF);
    check("pre_rst_pc", pc_out, 32'h00001000);
    rst = 1'b1;
    c_addr = 6'd7; c_data = 32'hBADBAD07;
    step();
    c_addr = 6'd32; c_data = 32'hBADBAD32;
    step();
    a_addr = 6'd7;
    #1;
    check("mid_rst_r7", a_data, 32'h0);
    check("mid_rst_pc", pc_out, 32'h0);
    check("mid_rst_psr", {28'h0, psr_out}, 32'h0);
    rst = 1'b0;
    c_addr = 6'd7; c_data = 32'h13572468;
    {neg_n, zer_n, ovf_n, car_n} = 4'b1110;
    step();
    check("post_rst_r7", a_data, 32'h13572468);
    check("post_rst_psr", {28'h0, psr_out}, 32'h1);
    idle();
    scan_model("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
